// File: rtl/des_io_pkg.sv
// des_io_pkg: shared types and width helpers for the DES I/O controller.
// Optional feature macro used by des_io_ctrl: DES_IO_ZEROIZE_EN.
package des_io_pkg;

    // Controller state: load a block, iterate rounds, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUND = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam int DEFAULT_BLOCK_W = 64;
    localparam int DEFAULT_HALF_W  = DEFAULT_BLOCK_W / 2;

    // Width of one half (left or right) of a block.
    function automatic int half_w(input int block_w);
        return block_w / 2;
    endfunction

endpackage

// File: rtl/des_round_counter.sv
// des_round_counter: round index with synchronous clear and enable, plus a
// terminal-count flag that is high on the last round.
module des_round_counter #(
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/des_io_ctrl.sv
// des_io_ctrl: accepts a block over valid/ready, iterates it through the
// external round logic NUM_ROUNDS times, then presents the swapped result.
// Define DES_IO_ZEROIZE_EN to clear the halves on every return to IDLE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are decoded from the registered state
// only, so neither depends combinationally on in_valid or out_ready.
module des_io_ctrl
    import des_io_pkg::*;
#(
    parameter int BLOCK_W    = 64,
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BLOCK_W-1:0]       ext_in,
    input  logic [BLOCK_W-1:0]       int_in,
    output logic [BLOCK_W/2-1:0]     data_out_left,
    output logic [BLOCK_W/2-1:0]     data_out_right,
    output logic [CNT_W-1:0]         round_idx,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BLOCK_W-1:0]       ext_out,
    output state_e                   state_dbg
);

    localparam int HALF_W = half_w(BLOCK_W);

    state_e              state_q;
    state_e              state_d;
    logic [HALF_W-1:0]   left_q;
    logic [HALF_W-1:0]   left_d;
    logic [HALF_W-1:0]   right_q;
    logic [HALF_W-1:0]   right_d;
    logic                accept;
    logic                round_tc;
    logic                cnt_clr;
    logic                cnt_en;

    assign accept  = (state_q == IDLE) && in_valid && !abort;
    assign cnt_clr = abort || accept || ((state_q == ROUND) && round_tc);
    assign cnt_en  = (state_q == ROUND) && !abort;

    des_round_counter #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .CNT_W      (CNT_W)
    ) u_round_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (round_idx),
        .tc  (round_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort overrides both handshakes.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid) state_d = ROUND;
                ROUND:   if (round_tc) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == ROUND);
        out_valid = (state_q == DONE);
        state_dbg = state_q;
    end

    // Half registers: load on accept, recapture each round, optional clear.
    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        if (abort) begin
`ifdef DES_IO_ZEROIZE_EN
            left_d  = '0;
            right_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        left_d  = ext_in[BLOCK_W-1 -: HALF_W];
                        right_d = ext_in[HALF_W-1:0];
                    end
                end
                ROUND: begin
                    left_d  = int_in[BLOCK_W-1 -: HALF_W];
                    right_d = int_in[HALF_W-1:0];
                end
                DONE: begin
`ifdef DES_IO_ZEROIZE_EN
                    if (out_ready) begin
                        left_d  = '0;
                        right_d = '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Half storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_q  <= '0;
            right_q <= '0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign data_out_left  = left_q;
    assign data_out_right = right_q;
    assign ext_out        = {right_q, left_q};

endmodule

// File: tb/tb_des_io_ctrl.sv
// tb_des_io_ctrl: self-checking bench for des_io_ctrl (64-bit/16-round and
// 16-bit/1-round builds). The round function is modelled as +1 on each half.
module tb_des_io_ctrl;
    import des_io_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Main DUT: BLOCK_W = 64, NUM_ROUNDS = 16
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ext_in = '0;
    logic [63:0] int_in;
    logic [31:0] dl;
    logic [31:0] dr;
    logic [3:0]  round_idx;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] ext_out;
    state_e      state_dbg;

    // Sweep DUT: BLOCK_W = 16, NUM_ROUNDS = 1
    logic        abort_s = 1'b0;
    logic        in_valid_s = 1'b0;
    logic        in_ready_s;
    logic [15:0] ext_in_s = '0;
    logic [15:0] int_in_s;
    logic [7:0]  dl_s;
    logic [7:0]  dr_s;
    logic [0:0]  round_idx_s;
    logic        busy_s;
    logic        out_valid_s;
    logic        out_ready_s = 1'b0;
    logic [15:0] ext_out_s;
    state_e      state_dbg_s;

    assign int_in   = {dl + 32'd1, dr + 32'd1};
    assign int_in_s = {dl_s + 8'd1, dr_s + 8'd1};

    des_io_ctrl #(.BLOCK_W(64), .NUM_ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .ext_in(ext_in), .int_in(int_in),
        .data_out_left(dl), .data_out_right(dr), .round_idx(round_idx),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .ext_out(ext_out), .state_dbg(state_dbg)
    );

    des_io_ctrl #(.BLOCK_W(16), .NUM_ROUNDS(1)) dut_s (
        .clk(clk), .rst(rst), .abort(abort_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .ext_in(ext_in_s), .int_in(int_in_s),
        .data_out_left(dl_s), .data_out_right(dr_s), .round_idx(round_idx_s),
        .busy(busy_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .ext_out(ext_out_s), .state_dbg(state_dbg_s)
    );

    always #5 clk = ~clk;

    // Reference: n rounds of (+1, +1), then swap halves.
    function automatic logic [63:0] model_out(input logic [63:0] blk, input int n);
        logic [31:0] l;
        logic [31:0] r;
        l = blk[63:32] + 32'(n);
        r = blk[31:0] + 32'(n);
        return {r, l};
    endfunction

    function automatic logic [15:0] model_out_s(input logic [15:0] blk, input int n);
        logic [7:0] l;
        logic [7:0] r;
        l = blk[15:8] + 8'(n);
        r = blk[7:0] + 8'(n);
        return {r, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input logic [63:0] blk);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        ext_in   = blk;
        tick();
        in_valid = 1'b0;
        ext_in   = {$urandom, $urandom};
    endtask

    // Called one cycle after the accept edge; ends with the result presented.
    task automatic check_rounds(input logic [63:0] blk, input string tag);
        logic [63:0] exp_v;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (round_idx !== 4'(k) || busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_round k=%0d round_idx=%0d busy=%b out_valid=%b expected idx=%0d busy=1 out_valid=0",
                         tag, k, round_idx, busy, out_valid, k);
            end
            tick();
        end
        exp_v = model_out(blk, 16);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || ext_out !== exp_v || round_idx !== 4'd0) begin
            failures++;
            $display("FAIL %s_result out_valid=%b busy=%b ext_out=%h round_idx=%0d expected 1 0 %h 0",
                     tag, out_valid, busy, ext_out, round_idx, exp_v);
        end
    endtask

    // Hold out_ready low for d cycles, then complete the output handshake.
    task automatic release_block(input logic [63:0] exp_v, input int d, input string tag);
        out_ready = 1'b0;
        for (int i = 0; i < d; i++) begin
            tick();
            checks++;
            if (ext_out !== exp_v || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_hold cyc=%0d ext_out=%h out_valid=%b in_ready=%b expected %h 1 0",
                         tag, i, ext_out, out_valid, in_ready, exp_v);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_release in_ready=%b out_valid=%b expected 1 0", tag, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            ext_out !== 64'h0 || round_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset in_ready=%b out_valid=%b busy=%b ext_out=%h round_idx=%0d expected 1 0 0 0 0",
                     in_ready, out_valid, busy, ext_out, round_idx);
        end
        checks++;
        if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0 || ext_out_s !== 16'h0) begin
            failures++;
            $display("FAIL reset_small in_ready=%b out_valid=%b ext_out=%h expected 1 0 0",
                     in_ready_s, out_valid_s, ext_out_s);
        end
    endtask

    task automatic test_single_block();
        out_ready = 1'b0;
        accept_block(64'h0123456789ABCDEF);
        check_rounds(64'h0123456789ABCDEF, "single");
        checks++;
        if (ext_out !== 64'h89ABCDFF01234577) begin
            failures++;
            $display("FAIL single_vector ext_out=%h expected 89abcdff01234577", ext_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] blk2;
        logic [63:0] blk3;
        blk2 = {$urandom, $urandom};
        blk3 = {$urandom, $urandom};
        // Still in DONE from the single-block test.
        release_block(64'h89ABCDFF01234577, 5, "bp");
        // Second block accepted in the first IDLE cycle.
        in_valid = 1'b1;
        ext_in   = blk2;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_rounds(blk2, "b2b_a");
        // in_valid raised while DONE: must not be taken until IDLE.
        in_valid = 1'b1;
        ext_in   = blk3;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap in_ready=%b busy=%b out_valid=%b expected 1 0 0", in_ready, busy, out_valid);
        end
        tick();
        in_valid = 1'b0;
        check_rounds(blk3, "b2b_b");
        release_block(model_out(blk3, 16), 0, "b2b_b");
        // Random blocks with random output backpressure.
        for (int n = 0; n < 4; n++) begin
            logic [63:0] blk;
            blk = {$urandom, $urandom};
            accept_block(blk);
            check_rounds(blk, "rand");
            release_block(model_out(blk, 16), int'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_abort_mid_round();
        logic [63:0] blk;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        blk = {$urandom, $urandom};
        accept_block(blk);
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (round_idx !== 4'd7) begin
            failures++;
            $display("FAIL abort_pre round_idx=%0d expected 7", round_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`ifdef DES_IO_ZEROIZE_EN
        exp_l = 32'h0;
        exp_r = 32'h0;
`else
        exp_l = blk[63:32] + 32'd7;
        exp_r = blk[31:0] + 32'd7;
`endif
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || round_idx !== 4'd0) begin
            failures++;
            $display("FAIL abort_state in_ready=%b busy=%b out_valid=%b round_idx=%0d expected 1 0 0 0",
                     in_ready, busy, out_valid, round_idx);
        end
        checks++;
        if (dl !== exp_l || dr !== exp_r || ext_out !== {exp_r, exp_l}) begin
            failures++;
            $display("FAIL abort_halves left=%h right=%h ext_out=%h expected %h %h",
                     dl, dr, ext_out, exp_l, exp_r);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] blk;
        abort    = 1'b1;
        in_valid = 1'b1;
        ext_in   = {$urandom, $urandom};
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_accept in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || round_idx !== 4'd0) begin
            failures++;
            $display("FAIL abort_accept_late busy=%b round_idx=%0d expected 0 0", busy, round_idx);
        end
        blk = {$urandom, $urandom};
        out_ready = 1'b0;
        accept_block(blk);
        check_rounds(blk, "rst_done");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dl !== 32'h0 || dr !== 32'h0 || ext_out !== 64'h0) begin
            failures++;
            $display("FAIL rst_in_done out_valid=%b in_ready=%b left=%h right=%h ext_out=%h expected 0 1 0 0 0",
                     out_valid, in_ready, dl, dr, ext_out);
        end
        // Reset mid-round discards the block.
        blk = {$urandom, $urandom};
        accept_block(blk);
        for (int k = 0; k < int'($urandom_range(1, 12)); k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || round_idx !== 4'd0 || ext_out !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid_round busy=%b in_ready=%b round_idx=%0d ext_out=%h expected 0 1 0 0",
                     busy, in_ready, round_idx, ext_out);
        end
    endtask

    task automatic test_sweep_small();
        logic [15:0] blk;
        for (int n = 0; n < 5; n++) begin
            blk = (n == 0) ? 16'hA1B2 : 16'($urandom);
            out_ready_s = 1'b0;
            in_valid_s  = 1'b1;
            ext_in_s    = blk;
            tick();
            in_valid_s  = 1'b0;
            ext_in_s    = 16'($urandom);
            checks++;
            if (busy_s !== 1'b1 || round_idx_s !== 1'b0 || out_valid_s !== 1'b0) begin
                failures++;
                $display("FAIL small_round n=%0d busy=%b round_idx=%0d out_valid=%b expected 1 0 0",
                         n, busy_s, round_idx_s, out_valid_s);
            end
            tick();
            checks++;
            if (out_valid_s !== 1'b1 || ext_out_s !== model_out_s(blk, 1)) begin
                failures++;
                $display("FAIL small_result n=%0d out_valid=%b ext_out=%h expected 1 %h",
                         n, out_valid_s, ext_out_s, model_out_s(blk, 1));
            end
            if (n == 0) begin
                checks++;
                if (ext_out_s !== 16'hB3A2) begin
                    failures++;
                    $display("FAIL small_vector ext_out=%h expected b3a2", ext_out_s);
                end
            end
            out_ready_s = 1'b1;
            tick();
            out_ready_s = 1'b0;
            checks++;
            if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin
                failures++;
                $display("FAIL small_release n=%0d in_ready=%b out_valid=%b expected 1 0",
                         n, in_ready_s, out_valid_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_abort_mid_round();
        test_simultaneous();
        test_sweep_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
